// File: rtl/fifo_pkg.sv
// Gray/binary conversion helpers shared by the write- and read-side
// FIFO controllers. The helpers work on 32-bit vectors. Callers zero-extend
// a narrower pointer on the way in and truncate the result on the way out.
// Zero upper bits do not change the low bits of either conversion.
package fifo_pkg;

   localparam int PTR_MAX_W = 32;

   // Binary to reflected Gray code.
   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reflected Gray code to binary. Each binary bit is the XOR of all
   // Gray bits at or above its position.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b = g;
      for (int i = 1; i < PTR_MAX_W; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_write_ctrl_sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded pointer.
// A Gray pointer changes at most one bit per source edge, so a
// plain per-bit double flop yields either the old or the new value.
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q1;
   logic [WIDTH-1:0] r_q2;

   // Shift the asynchronous input through two flops. Both flops clear on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q1 <= '0;
         r_q2 <= '0;
      end else begin
         r_q1 <= i_d;
         r_q2 <= r_q1;
      end
   end

   assign o_q = r_q2;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of the dual-clock FIFO (wclk domain only).
// - Accepts words from a valid/ready producer.
// - Drives the memory write port.
// - Keeps the binary and Gray write pointers.
// - Synchronizes the read Gray pointer into wclk.
// - Derives full, almost_full and the write-side occupancy.
module fifo_write_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6
) (
   input  logic                  wclk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wcount
);

   // Pointer width: one extra MSB separates full from empty.
   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] r_wbin;
   logic [PW-1:0] r_wgray;
   logic          r_full;

   logic          w_push;
   logic [PW-1:0] w_wbin_next;
   logic [PW-1:0] w_wgray_next;
   logic [PW-1:0] w_rq2;
   logic [PW-1:0] w_rbin;
   logic [PW-1:0] w_full_pat;
   logic [PW-1:0] w_wcount;

   // The read pointer enters this domain only through the synchronizer.
   sync_2ff #(
      .WIDTH (PW)
   ) u_rptr_sync (
      .clk   (wclk),
      .rst_n (rst_n),
      .i_d   (rptr_gray),
      .o_q   (w_rq2)
   );

   // A push needs a word, room, and no active reset. The reset gate keeps
   // wen low while reset is held, even if the producer is presenting data.
   assign w_push = in_valid && !r_full && rst_n;

   assign w_wbin_next  = r_wbin + PW'(w_push);
   assign w_wgray_next = PW'(bin2gray(PTR_MAX_W'(w_wbin_next)));

   // Full when the write pointer is exactly one lap ahead of the read pointer.
   // In Gray code that means the top two bits are inverted and the rest
   // are equal. A 1-bit address has only those two bits.
   generate
      if (ADDR_WIDTH >= 2) begin : g_full_pat_wide
         assign w_full_pat = {~w_rq2[PW-1:PW-2], w_rq2[PW-3:0]};
      end else begin : g_full_pat_narrow
         assign w_full_pat = ~w_rq2;
      end
   endgenerate

   // Advance the pointers on a push and register the look-ahead full flag.
   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_full  <= 1'b0;
      end else begin
         r_wbin  <= w_wbin_next;
         r_wgray <= w_wgray_next;
         r_full  <= (w_wgray_next == w_full_pat);
      end
   end

   // The occupancy uses the stale synchronized read pointer. It can
   // therefore over-report after a read, but it never under-reports.
   assign w_rbin   = PW'(gray2bin(PTR_MAX_W'(w_rq2)));
   assign w_wcount = r_wbin - w_rbin;

   assign in_ready    = !r_full;
   assign wen         = w_push;
   assign waddr       = r_wbin[ADDR_WIDTH-1:0];
   assign wdata       = in_data;
   assign wptr_gray   = r_wgray;
   assign full        = r_full;
   assign wcount      = w_wcount;
   assign almost_full = (w_wcount >= PW'(AF_THRESH));

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl with hand-computed expectations.
module tb_fifo_write_ctrl;

   logic       wclk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       wen;
   logic [2:0] waddr;
   logic [3:0] wdata;
   logic [3:0] wptr_gray;
   logic [3:0] rptr_gray;
   logic       full;
   logic       almost_full;
   logic [3:0] wcount;

   int n_cmp = 0;
   int n_err = 0;

   fifo_write_ctrl #(
      .DATA_WIDTH (4),
      .ADDR_WIDTH (3),
      .AF_THRESH  (6)
   ) dut (
      .wclk        (wclk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .wen         (wen),
      .waddr       (waddr),
      .wdata       (wdata),
      .wptr_gray   (wptr_gray),
      .rptr_gray   (rptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .wcount      (wcount)
   );

   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   // Reset between clock edges, then release between edges.
   task automatic do_reset();
      in_valid  = 1'b0;
      rptr_gray = 4'b0000;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [3:0] g4(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   logic [3:0] g_prev;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'h5;
      rptr_gray = 4'b0000;

      // Reset held with a word presented: nothing may be written.
      tick();
      tick();
      chk("rst_wen", wen, 0);
      chk("rst_full", full, 0);
      chk("rst_wcount", wcount, 0);
      chk("rst_wptr", wptr_gray, 0);
      chk("rst_af", almost_full, 0);
      #2 rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rel_in_ready", in_ready, 1);
      chk("rel_wen", wen, 0);
      tick();

      // Fill 8 words with the read pointer held at 0.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i + 1);
         #1;
         chk($sformatf("fill%0d_waddr", i), waddr, i);
         chk($sformatf("fill%0d_wen", i), wen, 1);
         chk($sformatf("fill%0d_wdata", i), wdata, i + 1);
         tick();
         chk($sformatf("fill%0d_wcount", i), wcount, i + 1);
         chk($sformatf("fill%0d_af", i), almost_full, (i + 1 >= 6) ? 1 : 0);
         chk($sformatf("fill%0d_full", i), full, (i == 7) ? 1 : 0);
      end
      chk("fill_wptr", wptr_gray, 4'b1100);
      in_valid = 1'b1;
      in_data  = 4'h9;
      #1;
      chk("ovf_wen", wen, 0);
      chk("ovf_in_ready", in_ready, 0);
      chk("ovf_waddr", waddr, 0);
      tick();
      chk("ovf_wcount", wcount, 8);
      chk("ovf_wptr", wptr_gray, 4'b1100);

      // Drain release: the read pointer moves to 1.
      in_valid  = 1'b0;
      rptr_gray = 4'b0001;
      tick();
      chk("drain_e1_full", full, 1);
      tick();
      chk("drain_e2_full", full, 1);
      chk("drain_e2_wcount", wcount, 7);
      tick();
      chk("drain_e3_full", full, 0);
      chk("drain_e3_wcount", wcount, 7);
      in_valid = 1'b1;
      in_data  = 4'h9;
      #1;
      chk("drain_push_wen", wen, 1);
      chk("drain_push_waddr", waddr, 0);
      tick();
      in_valid = 1'b0;
      chk("drain_push_full", full, 1);
      chk("drain_push_wcount", wcount, 8);

      // Simultaneous events: free one slot, then push while the read pointer advances.
      rptr_gray = g4(2);
      tick();
      tick();
      tick();
      chk("sim_pre_full", full, 0);
      chk("sim_pre_wcount", wcount, 7);
      in_valid = 1'b1;
      in_data  = 4'hA;
      #1;
      chk("sim_wen", wen, 1);
      chk("sim_waddr", waddr, 1);
      tick();
      in_valid  = 1'b0;
      rptr_gray = g4(3);
      chk("sim_e0_full", full, 1);
      chk("sim_e0_wcount", wcount, 8);
      tick();
      chk("sim_e1_full", full, 1);
      tick();
      chk("sim_e2_full", full, 1);
      chk("sim_e2_wcount", wcount, 7);
      tick();
      chk("sim_e3_full", full, 0);
      chk("sim_e3_wcount", wcount, 7);
      chk("sim_next_waddr", waddr, 2);

      // Wrap: stream 20 pushes with the read pointer trailing by one cycle.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i);
         #1;
         chk($sformatf("wrap%0d_waddr", i), waddr, i % 8);
         chk($sformatf("wrap%0d_wen", i), wen, 1);
         g_prev = wptr_gray;
         tick();
         chk($sformatf("wrap%0d_gray", i), wptr_gray, g4((i + 1) % 16));
         chk($sformatf("wrap%0d_1bit", i), $countones(g_prev ^ wptr_gray), 1);
         chk($sformatf("wrap%0d_full", i), full, 0);
         rptr_gray = g_prev;
      end
      in_valid = 1'b0;
      #1;
      chk("wrap_end_waddr", waddr, 4);
      chk("wrap_end_wptr", wptr_gray, 4'b0110);

      // Mid-operation reset at wcount=5.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i + 3);
         tick();
      end
      chk("mid_wcount", wcount, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_wcount", wcount, 0);
      chk("mid_rst_wptr", wptr_gray, 0);
      chk("mid_rst_waddr", waddr, 0);
      chk("mid_rst_wen", wen, 0);
      chk("mid_rst_full", full, 0);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_wen", wen, 1);
      chk("mid_rel_waddr", waddr, 0);
      tick();
      in_valid = 1'b0;
      chk("mid_rel_wcount", wcount, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
